uart_link_ctrl: RTL and testbench

- Frame-level controller sitting between the uart byte module and the perceptron core.
- Parses inbound frames from uart receive outputs (SOF, length, payload, XOR checksum) and streams payload bytes into the core's load port.
- Waits for the core's result, then sequences uart transmit to send ACK+result or NAK.
- Owns all handshaking with the uart: clear pulses, start_transmit, data hold.

---
 rtl/uart_link_pkg.sv | 16 +
 rtl/uart_tx_seq.sv | 54 +++++
 rtl/uart_link_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_link_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// uart_link_pkg: shared frame bytes and state encodings for uart_link_ctrl and uart_tx_seq.
package uart_link_pkg;

   localparam logic [7:0] SOF = 8'hA5;
   localparam logic [7:0] ACK = 8'h5A;
   localparam logic [7:0] NAK = 8'hEE;

   typedef enum logic [2:0] {
      IDLE, LEN, PAYLOAD, CSUM, WAIT_RES, TX_ACK, TX_RES, TX_NAK
   } link_state_t;

   typedef enum logic [1:0] {
      TX_IDLE, TX_WAIT_HI, TX_WAIT_LO
   } tx_state_t;

endpackage

// File: rtl/uart_tx_seq.sv
// uart_tx_seq: sends one byte through the uart transmitter per request.
//   clk, rst_n      clock, asynchronous active-low reset
//   req, byte_in    request to send byte_in (held until done)
//   done            one-cycle pulse once the uart has finished the byte
//   tx_busy         uart transmitter busy
//   tx_start        one-cycle pulse to uart start_transmit
//   tx_data         byte to uart data_to_send, held through the transfer
module uart_tx_seq
   import uart_link_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic [7:0] byte_in,
   output logic       done,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data
);

   tx_state_t st_q, st_d;
   logic      start_d;

   always_comb begin
      st_d    = st_q;
      start_d = 1'b0;
      done    = 1'b0;
      case (st_q)
         TX_IDLE:    if (req && !tx_busy) begin
                        start_d = 1'b1;
                        st_d    = TX_WAIT_HI;
                     end
         TX_WAIT_HI: if (tx_busy) st_d = TX_WAIT_LO;
         TX_WAIT_LO: if (!tx_busy) begin
                        done = 1'b1;
                        st_d = TX_IDLE;
                     end
         default:    st_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q     <= TX_IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         st_q     <= st_d;
         tx_start <= start_d;
         if (start_d) tx_data <= byte_in;
      end
   end

endmodule

// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: frame parser / responder between the uart byte module and the perceptron core.
//   Frame: SOF(A5), length L (1..MAX_LEN), L payload bytes, XOR checksum.
//   Good frame -> payload streamed on pl_*, frame_done, wait for result, send ACK(5A)+result.
//   Bad frame  -> frame_err, send NAK(EE).
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_new_value/rx_data/rx_error, rx_clear   uart receive side
//   tx_start/tx_data, tx_busy  uart transmit side
//   pl_we/pl_addr/pl_data, frame_done, frame_err   core payload load port
//   res_valid/res_data, res_ready                  core result handshake
//   link_busy                  high whenever not IDLE
//   Build option UART_TIMEOUT_EN: NAK a frame whose inter-byte gap reaches TIMEOUT_CYCLES.
module uart_link_ctrl
   import uart_link_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 12000000,
   parameter int MAX_LEN         = 16,
   parameter int TIMEOUT_CYCLES  = 120000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_new_value,
   input  logic [7:0] rx_data,
   input  logic       rx_error,
   output logic       rx_clear,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   output logic       pl_we,
   output logic [7:0] pl_addr,
   output logic [7:0] pl_data,
   output logic       frame_done,
   output logic       frame_err,
   input  logic       res_valid,
   input  logic [7:0] res_data,
   output logic       res_ready,
   output logic       link_busy
);

   if (MAX_LEN < 1 || MAX_LEN > 255 || CLOCK_FREQUENCY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("uart_link_ctrl: parameter out of range");
   end

   link_state_t state_q, state_d;
   logic        rx_state, evt, byte_v, err_v, to_hit;
   logic [1:0]  guard_q;
   logic [7:0]  byte_q, len_q, len_d, idx_q, idx_d, csum_q, csum_d, res_q;
   logic        we_d, done_d, err_d, tx_req, tx_done;
   logic [7:0]  tx_byte;

   assign rx_state  = state_q inside {IDLE, LEN, PAYLOAD, CSUM};
   assign link_busy = state_q != IDLE;

   // Capture stage: the uart flag stays up until it sees our clear pulse, so
   // block the clear cycle itself and the two guard cycles after it.
   assign evt = rx_state && !rx_clear && guard_q == 2'd0 && (rx_new_value || rx_error);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_clear <= 1'b0;
         byte_v   <= 1'b0;
         err_v    <= 1'b0;
         byte_q   <= 8'h00;
         guard_q  <= 2'd0;
      end else begin
         rx_clear <= evt;
         byte_v   <= evt && !rx_error;
         err_v    <= evt && rx_error;
         if (evt) byte_q <= rx_data;
         guard_q  <= rx_clear ? 2'd2 : (guard_q != 2'd0 ? guard_q - 2'd1 : 2'd0);
      end
   end

`ifdef UART_TIMEOUT_EN
   logic [31:0] to_cnt;
   logic        to_run;
   assign to_run = state_q inside {LEN, PAYLOAD, CSUM};
   assign to_hit = to_run && to_cnt == 32'(TIMEOUT_CYCLES);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) to_cnt <= 32'd0;
      else        to_cnt <= (evt || !to_run) ? 32'd0 : to_cnt + 32'd1;
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      csum_d    = csum_q;
      we_d      = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      res_ready = 1'b0;
      tx_req    = 1'b0;
      tx_byte   = NAK;
      case (state_q)
         IDLE:     if (byte_v && byte_q == SOF) state_d = LEN;
         LEN:      if (err_v || to_hit) err_d = 1'b1;
                   else if (byte_v) begin
                      if (byte_q == 8'd0 || byte_q > 8'(MAX_LEN)) err_d = 1'b1;
                      else begin
                         len_d   = byte_q;
                         idx_d   = 8'd0;
                         csum_d  = 8'd0;
                         state_d = PAYLOAD;
                      end
                   end
         PAYLOAD:  if (err_v || to_hit) err_d = 1'b1;
                   else if (byte_v) begin
                      we_d   = 1'b1;
                      csum_d = csum_q ^ byte_q;
                      idx_d  = idx_q + 8'd1;
                      if (idx_q + 8'd1 == len_q) state_d = CSUM;
                   end
         CSUM:     if (err_v || to_hit) err_d = 1'b1;
                   else if (byte_v) begin
                      if (byte_q == csum_q) begin
                         done_d  = 1'b1;
                         state_d = WAIT_RES;
                      end else err_d = 1'b1;
                   end
         WAIT_RES: if (res_valid) begin
                      res_ready = 1'b1;
                      state_d   = TX_ACK;
                   end
         TX_ACK:   begin
                      tx_req  = 1'b1;
                      tx_byte = ACK;
                      if (tx_done) state_d = TX_RES;
                   end
         TX_RES:   begin
                      tx_req  = 1'b1;
                      tx_byte = res_q;
                      if (tx_done) state_d = IDLE;
                   end
         TX_NAK:   begin
                      tx_req = 1'b1;
                      if (tx_done) state_d = IDLE;
                   end
         default:  state_d = IDLE;
      endcase
      if (err_d) state_d = TX_NAK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= 8'd0;
         idx_q      <= 8'd0;
         csum_q     <= 8'd0;
         res_q      <= 8'd0;
         pl_we      <= 1'b0;
         pl_addr    <= 8'd0;
         pl_data    <= 8'd0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         csum_q     <= csum_d;
         pl_we      <= we_d;
         frame_done <= done_d;
         frame_err  <= err_d;
         if (res_ready) res_q <= res_data;
         if (we_d) begin
            pl_addr <= idx_q;
            pl_data <= byte_q;
         end
      end
   end

   uart_tx_seq u_tx_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (tx_req),
      .byte_in  (tx_byte),
      .done     (tx_done),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data)
   );

endmodule

// File: tb/tb_uart_link_ctrl.sv
// tb_uart_link_ctrl: directed frames against uart_link_ctrl with a simple uart model.
module tb_uart_link_ctrl;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       rx_new_value = 1'b0, rx_error = 1'b0, res_valid = 1'b0;
   logic [7:0] rx_data = 8'h00, res_data = 8'h00;
   logic       rx_clear, tx_start, tx_busy, pl_we, frame_done, frame_err, res_ready, link_busy;
   logic [7:0] tx_data, pl_addr, pl_data;

   int n_vec = 0, n_bad = 0;
   int cyc = 0, done_cnt = 0, err_cnt = 0, rr_cnt = 0, done_cyc = 0, bcnt = 0;
   int last_rx_cyc = 0;
   logic [15:0] wq[$];
   logic [7:0]  txq[$];
   logic [7:0]  v[8];
   int d0, e0, w0, t0;

   always #5 clk = ~clk;

   uart_link_ctrl #(.MAX_LEN(16), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_new_value(rx_new_value), .rx_data(rx_data), .rx_error(rx_error), .rx_clear(rx_clear),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data),
      .frame_done(frame_done), .frame_err(frame_err),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .link_busy(link_busy)
   );

   assign tx_busy = bcnt != 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) bcnt <= 0;
      else if (tx_start) bcnt <= 5;
      else if (bcnt != 0) bcnt <= bcnt - 1;
      if (pl_we) wq.push_back({pl_addr, pl_data});
      if (tx_start) txq.push_back(tx_data);
      if (frame_done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (frame_err) err_cnt <= err_cnt + 1;
      if (res_ready) rr_cnt <= rr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] wat(input int i);
      return i < wq.size() ? wq[i] : 16'hFFFF;
   endfunction

   function automatic logic [15:0] tat(input int i);
      return i < txq.size() ? {8'h00, txq[i]} : 16'hFFFF;
   endfunction

   function automatic logic [31:0] outs();
      return {1'b0, link_busy, tx_start, rx_clear, pl_we, frame_done, frame_err, res_ready,
              tx_data, pl_addr, pl_data};
   endfunction

   task automatic snap();
      d0 = done_cnt; e0 = err_cnt; w0 = wq.size(); t0 = txq.size();
   endtask

   task automatic rx_put(input logic [7:0] b, input logic e);
      int n = 0;
      @(posedge clk); #1;
      rx_data = b; rx_new_value = 1'b1; rx_error = e; last_rx_cyc = cyc;
      while (!rx_clear && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rx_clear", {31'd0, rx_clear}, 32'd1);
      @(posedge clk); #1;
      rx_new_value = 1'b0; rx_error = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic send(input int n);
      for (int i = 0; i < n; i++) rx_put(v[i], 1'b0);
   endtask

   task automatic give_res(input logic [7:0] r);
      @(posedge clk); #1;
      res_valid = 1'b1; res_data = r;
      @(posedge clk); #1;
      res_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (link_busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, link_busy}, 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset outs", outs(), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // good frame, checksum 11^22^33 = 00
      snap();
      v = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
      send(6);
      chk("t1 done", done_cnt - d0, 1);
      chk("t1 latency", done_cyc - last_rx_cyc, 2);
      chk("t1 err", err_cnt - e0, 0);
      chk("t1 nwr", wq.size() - w0, 3);
      chk("t1 wr0", wat(w0), 16'h0011);
      chk("t1 wr1", wat(w0 + 1), 16'h0122);
      chk("t1 wr2", wat(w0 + 2), 16'h0233);
      chk("t1 busy", {31'd0, link_busy}, 1);
      give_res(8'h7C);
      chk("t1 res_ready", rr_cnt, 1);
      wait_idle("t1 idle");
      chk("t1 ntx", txq.size() - t0, 2);
      chk("t1 tx0", tat(t0), 8'h5A);
      chk("t1 tx1", tat(t0 + 1), 8'h7C);

      // bad checksum: 10^20 = 30, 31 sent
      snap();
      v = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31, 8'h00, 8'h00, 8'h00};
      send(5);
      chk("t2 done", done_cnt - d0, 0);
      chk("t2 err", err_cnt - e0, 1);
      chk("t2 nwr", wq.size() - w0, 2);
      wait_idle("t2 idle");
      chk("t2 ntx", txq.size() - t0, 1);
      chk("t2 tx0", tat(t0), 8'hEE);

      // junk before SOF dropped silently
      snap();
      v = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h42, 8'h42, 8'h00, 8'h00};
      send(6);
      chk("t3 done", done_cnt - d0, 1);
      chk("t3 err", err_cnt - e0, 0);
      chk("t3 nwr", wq.size() - w0, 1);
      chk("t3 wr0", wat(w0), 16'h0042);
      give_res(8'h99);
      wait_idle("t3 idle");
      chk("t3 ntx", txq.size() - t0, 2);
      chk("t3 tx0", tat(t0), 8'h5A);
      chk("t3 tx1", tat(t0 + 1), 8'h99);

      // length 0 and length 17
      snap();
      v = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send(2);
      chk("t4a err", err_cnt - e0, 1);
      wait_idle("t4a idle");
      chk("t4a tx0", tat(t0), 8'hEE);
      v[1] = 8'h11;
      send(2);
      chk("t4b err", err_cnt - e0, 2);
      wait_idle("t4b idle");
      chk("t4b tx1", tat(t0 + 1), 8'hEE);
      chk("t4 nwr", wq.size() - w0, 0);
      chk("t4 ntx", txq.size() - t0, 2);

      // rx_error (with a simultaneous byte) on payload byte 2
      snap();
      v = '{8'hA5, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send(3);
      rx_put(8'h55, 1'b1);
      chk("t5 err", err_cnt - e0, 1);
      chk("t5 done", done_cnt - d0, 0);
      chk("t5 nwr", wq.size() - w0, 1);
      chk("t5 wr0", wat(w0), 16'h0001);
      wait_idle("t5 idle");
      chk("t5 ntx", txq.size() - t0, 1);
      chk("t5 tx0", tat(t0), 8'hEE);

      // reset while the ACK is on the wire
      snap();
      v = '{8'hA5, 8'h01, 8'h42, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00};
      send(4);
      give_res(8'h33);
      begin
         int n = 0;
         @(negedge clk);
         while (!tx_start && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("t6 ack start", {31'd0, tx_start}, 1);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6 reset outs", outs(), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("t6 ntx", txq.size() - t0, 1);
      chk("t6 tx0", tat(t0), 8'h5A);
      chk("t6 idle", {31'd0, link_busy}, 0);

      // silence mid-payload
      snap();
      v = '{8'hA5, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send(3);
      repeat (300) @(posedge clk);
      @(negedge clk);
`ifdef UART_TIMEOUT_EN
      chk("t7 err", err_cnt - e0, 1);
      chk("t7 idle", {31'd0, link_busy}, 0);
      chk("t7 ntx", txq.size() - t0, 1);
      chk("t7 tx0", tat(t0), 8'hEE);
`else
      chk("t7 err", err_cnt - e0, 0);
      chk("t7 busy", {31'd0, link_busy}, 1);
      chk("t7 ntx", txq.size() - t0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
